// File: rtl/sd_cmd_responder_pkg.sv
// Shared types and constants for the SD card-side command responder.
package sd_cmd_responder_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StCheck,
        StWaitResp,
        StDelay,
        StSend
    } state_e;

    localparam int unsigned cCmdFrameLen = 48;
    localparam logic [6:0]  cCrc7Poly    = 7'h09;
    localparam logic [6:0]  cNoCrcField  = 7'h7F;

endpackage

// File: rtl/sd_cmd_responder_crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1) with zero seed; clear has priority over shift.
module crc7_serial
    import sd_cmd_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       shift_en,
    input  logic       data,
    output logic [6:0] crc
);

    logic [6:0] crc_q;
    logic       feedback;

    assign feedback = data ^ crc_q[6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else if (clear) begin
            crc_q <= '0;
        end else if (shift_en) begin
            crc_q <= {crc_q[5:0], 1'b0} ^ (feedback ? cCrc7Poly : 7'h00);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_responder.sv
// SD card-side CMD line engine: receives 48-bit command frames, checks them and
// sends the user's 48-bit response NCR cycles after the response handshake.
module sd_cmd_responder
    import sd_cmd_responder_pkg::*;
#(
    parameter int unsigned NCR          = 2,
    parameter int unsigned RESP_TIMEOUT = 64
) (
    input  logic        Clk,
    input  logic        nResetAsync,
    input  logic        CmdIn,
    output logic        CmdOut,
    output logic        CmdEn,
    output logic        CmdValid,
    output logic [5:0]  CmdIndex,
    output logic [31:0] CmdArg,
    output logic        CrcError,
    input  logic        RespValid,
    output logic        RespReady,
    input  logic        RespSkip,
    input  logic [5:0]  RespIndex,
    input  logic [31:0] RespArg,
    input  logic        RespNoCrc,
    output logic        RespTimeout,
    output logic        Busy
);

    localparam int unsigned FrameLen = cCmdFrameLen;
    localparam int unsigned CrcBits  = FrameLen - 8;
    localparam int unsigned CntMaxA  = (RESP_TIMEOUT > FrameLen) ? RESP_TIMEOUT : FrameLen;
    localparam int unsigned CntMax   = (NCR > CntMaxA) ? NCR : CntMaxA;
    localparam int unsigned CntW     = $clog2(CntMax + 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [45:0]     rx_sr_q;
    logic [39:0]     tx_sr_q;
    logic            no_crc_q;
    logic            cmd_valid_q;
    logic            crc_err_q;
    logic [5:0]      index_q;
    logic [31:0]     arg_q;
    logic [6:0]      crc_rx;
    logic [6:0]      crc_tx;
    logic [6:0]      crc_field;
    logic [2:0]      crc_idx;
    logic            rx_last;
    logic            frame_ok;
    logic            handshake;
    logic            wait_expired;
    logic            tx_bit;

    // Frame bits 47..8 feed the CRC; the zero start bit leaves a cleared CRC at zero.
    crc7_serial u_crc_rx (
        .clk      (Clk),
        .rst_n    (nResetAsync),
        .clear    (state_q == StIdle),
        .shift_en ((state_q == StRecv) && (cnt_q < CntW'(CrcBits - 1))),
        .data     (CmdIn),
        .crc      (crc_rx)
    );

    crc7_serial u_crc_tx (
        .clk      (Clk),
        .rst_n    (nResetAsync),
        .clear    (state_q != StSend),
        .shift_en ((state_q == StSend) && (cnt_q < CntW'(CrcBits))),
        .data     (tx_sr_q[39]),
        .crc      (crc_tx)
    );

    // The decision is taken as the end bit arrives so CHECK already shows the new fields.
    assign rx_last      = (state_q == StRecv) && (cnt_q == CntW'(FrameLen - 2));
    assign frame_ok     = rx_sr_q[45] && (crc_rx == rx_sr_q[6:0]) && CmdIn;
    assign handshake    = (state_q == StWaitResp) && RespValid && !RespSkip;
    assign wait_expired = (cnt_q == CntW'(RESP_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!CmdIn) state_d = StRecv;
            end
            StRecv: begin
                if (rx_last) begin
                    state_d = StCheck;
                    cnt_d   = '0;
                end
            end
            StCheck: begin
                cnt_d   = '0;
                state_d = cmd_valid_q ? StWaitResp : StIdle;
            end
            StWaitResp: begin
                if (RespSkip || handshake || wait_expired) begin
                    cnt_d   = '0;
                    state_d = handshake ? StDelay : StIdle;
                end
            end
            StDelay: begin
                if (cnt_q == CntW'(NCR - 2)) begin
                    state_d = StSend;
                    cnt_d   = '0;
                end
            end
            StSend: begin
                if (cnt_q == CntW'(FrameLen - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge nResetAsync) begin
        if (!nResetAsync) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            no_crc_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            crc_err_q   <= 1'b0;
            index_q     <= '0;
            arg_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_valid_q <= rx_last && frame_ok;
            crc_err_q   <= rx_last && !frame_ok;
            if (state_q == StRecv) rx_sr_q <= {rx_sr_q[44:0], CmdIn};
            if (rx_last && frame_ok) begin
                index_q <= rx_sr_q[44:39];
                arg_q   <= rx_sr_q[38:7];
            end
            if (handshake) begin
                tx_sr_q  <= {2'b00, RespIndex, RespArg};
                no_crc_q <= RespNoCrc;
            end else if ((state_q == StSend) && (cnt_q < CntW'(CrcBits))) begin
                tx_sr_q <= {tx_sr_q[38:0], 1'b0};
            end
        end
    end

    assign crc_field = no_crc_q ? cNoCrcField : crc_tx;
    assign crc_idx   = 3'(CntW'(FrameLen - 2) - cnt_q);

    always_comb begin
        tx_bit = 1'b1;
        if (cnt_q < CntW'(CrcBits)) begin
            tx_bit = tx_sr_q[39];
        end else if (cnt_q < CntW'(FrameLen - 1)) begin
            tx_bit = crc_field[crc_idx];
        end
    end

    assign CmdEn       = (state_q == StSend);
    assign CmdOut      = CmdEn ? tx_bit : 1'b1;
    assign CmdValid    = cmd_valid_q;
    assign CrcError    = crc_err_q;
    assign CmdIndex    = index_q;
    assign CmdArg      = arg_q;
    assign RespReady   = (state_q == StWaitResp);
    assign RespTimeout = (state_q == StWaitResp) && !RespSkip && !RespValid && wait_expired;
    assign Busy        = (state_q != StIdle);

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Self-checking bench: directed frames plus randomized command/response traffic
// checked against a polynomial-division CRC model and a simple field model.
module tb_sd_cmd_responder;

    localparam int unsigned NCR_T = 3;
    localparam int unsigned TO_T  = 64;

    logic        Clk = 1'b0;
    logic        nResetAsync = 1'b0;
    logic        CmdIn = 1'b1;
    logic        CmdOut, CmdEn, CmdValid, CrcError, RespReady, RespTimeout, Busy;
    logic [5:0]  CmdIndex;
    logic [31:0] CmdArg;
    logic        RespValid = 1'b0;
    logic        RespSkip = 1'b0;
    logic        RespNoCrc = 1'b0;
    logic [5:0]  RespIndex = '0;
    logic [31:0] RespArg = '0;

    int          checks = 0;
    int          errors = 0;
    logic [5:0]  exp_index = '0;
    logic [31:0] exp_arg = '0;

    sd_cmd_responder #(
        .NCR          (NCR_T),
        .RESP_TIMEOUT (TO_T)
    ) dut (
        .Clk         (Clk),
        .nResetAsync (nResetAsync),
        .CmdIn       (CmdIn),
        .CmdOut      (CmdOut),
        .CmdEn       (CmdEn),
        .CmdValid    (CmdValid),
        .CmdIndex    (CmdIndex),
        .CmdArg      (CmdArg),
        .CrcError    (CrcError),
        .RespValid   (RespValid),
        .RespReady   (RespReady),
        .RespSkip    (RespSkip),
        .RespIndex   (RespIndex),
        .RespArg     (RespArg),
        .RespNoCrc   (RespNoCrc),
        .RespTimeout (RespTimeout),
        .Busy        (Busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // CRC7 as the remainder of m(x)*x^7 divided by x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_model(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, crc7_model({2'b01, idx, arg}), 1'b1};
    endfunction

    function automatic logic frame_good(input logic [47:0] f);
        return f[46] && f[0] && (crc7_model(f[47:8]) == f[7:1]);
    endfunction

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    // Drives a frame starting from IDLE; leaves the DUT in WAIT_RESP or IDLE.
    task automatic send_frame(input logic [47:0] f, input string name);
        logic ok;
        ok = frame_good(f);
        for (int i = 47; i >= 0; i--) begin
            CmdIn = f[i];
            step();
        end
        CmdIn = 1'b1;
        checks++;
        if (CmdValid !== ok || CrcError !== !ok) begin
            errors++;
            $display("FAIL %s flags: CmdValid=%b CrcError=%b, want %b/%b",
                     name, CmdValid, CrcError, ok, !ok);
        end
        if (ok) begin
            exp_index = f[45:40];
            exp_arg   = f[39:8];
        end
        checks++;
        if (CmdIndex !== exp_index || CmdArg !== exp_arg) begin
            errors++;
            $display("FAIL %s fields: index=%h arg=%h, want %h %h",
                     name, CmdIndex, CmdArg, exp_index, exp_arg);
        end
        step();
        checks++;
        if (RespReady !== ok || Busy !== ok || CmdValid !== 1'b0 || CrcError !== 1'b0) begin
            errors++;
            $display("FAIL %s after check: RespReady=%b Busy=%b CmdValid=%b CrcError=%b, want %b %b 0 0",
                     name, RespReady, Busy, CmdValid, CrcError, ok, ok);
        end
    endtask

    // Handshake from WAIT_RESP and capture the whole response frame.
    task automatic respond(input logic [5:0] idx, input logic [31:0] arg, input logic nocrc,
                           input string name);
        logic [47:0] expf;
        logic [47:0] got;
        logic        en_ok;
        int          lat;
        expf = {2'b00, idx, arg, nocrc ? 7'h7F : crc7_model({2'b00, idx, arg}), 1'b1};
        checks++;
        if (RespReady !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: RespReady=%b, want 1", name, RespReady);
        end
        RespValid = 1'b1;
        RespIndex = idx;
        RespArg   = arg;
        RespNoCrc = nocrc;
        step();
        RespValid = 1'b0;
        RespIndex = 6'($urandom);
        RespArg   = $urandom;
        RespNoCrc = 1'($urandom);
        lat = 1;
        while (CmdEn !== 1'b1 && lat < int'(NCR_T) + 8) begin
            step();
            lat++;
        end
        checks++;
        if (lat != int'(NCR_T)) begin
            errors++;
            $display("FAIL %s latency: first bit after %0d cycles, want %0d", name, lat, NCR_T);
        end
        en_ok = 1'b1;
        got   = '0;
        for (int i = 47; i >= 0; i--) begin
            got[i] = CmdOut;
            if (CmdEn !== 1'b1) en_ok = 1'b0;
            CmdIn = 1'($urandom);
            step();
        end
        CmdIn = 1'b1;
        checks++;
        if (got !== expf) begin
            errors++;
            $display("FAIL %s frame: got %h, want %h", name, got, expf);
        end
        checks++;
        if (en_ok !== 1'b1) begin
            errors++;
            $display("FAIL %s enable: CmdEn dropped during 48 send cycles, want held high", name);
        end
        checks++;
        if (CmdEn !== 1'b0 || CmdOut !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s release: CmdEn=%b CmdOut=%b Busy=%b, want 0 1 0",
                     name, CmdEn, CmdOut, Busy);
        end
    endtask

    task automatic skip(input logic with_valid, input string name);
        logic quiet;
        RespSkip  = 1'b1;
        RespValid = with_valid;
        step();
        RespSkip  = 1'b0;
        RespValid = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (CmdEn !== 1'b0 || Busy !== 1'b0 || CmdOut !== 1'b1) quiet = 1'b0;
            step();
        end
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL %s skip: line driven or busy after skip, want idle", name);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (CmdEn !== 1'b0 || CmdOut !== 1'b1 || CmdValid !== 1'b0 || CrcError !== 1'b0 ||
            RespReady !== 1'b0 || RespTimeout !== 1'b0 || Busy !== 1'b0 ||
            CmdIndex !== 6'd0 || CmdArg !== 32'd0) begin
            errors++;
            $display("FAIL reset: En=%b Out=%b V=%b E=%b Rdy=%b TO=%b Busy=%b idx=%h arg=%h",
                     CmdEn, CmdOut, CmdValid, CrcError, RespReady, RespTimeout, Busy,
                     CmdIndex, CmdArg);
        end
        #3 nResetAsync = 1'b1;
        step();
    endtask

    task automatic test_cmd0_skip();
        send_frame(48'h400000000095, "cmd0");
        skip(1'b0, "cmd0");
    endtask

    task automatic test_cmd8_response();
        send_frame(48'h48000001AA87, "cmd8");
        respond(6'd8, 32'h000001AA, 1'b0, "cmd8_resp");
    endtask

    task automatic test_crc_error();
        logic [47:0] f;
        f = 48'h48000001AA87 ^ (48'h1 << 20);
        send_frame(f, "cmd8_flipped");
        send_frame(make_cmd(6'd17, $urandom), "after_reject");
        skip(1'b1, "after_reject");
    endtask

    task automatic test_timeout();
        logic ready_ok, pulse_ok, line_ok;
        send_frame(make_cmd(6'd55, $urandom), "timeout_cmd");
        ready_ok = 1'b1;
        pulse_ok = 1'b1;
        line_ok  = 1'b1;
        for (int k = 1; k <= int'(TO_T); k++) begin
            if (RespReady !== 1'b1) ready_ok = 1'b0;
            if (RespTimeout !== (k == int'(TO_T))) pulse_ok = 1'b0;
            if (CmdEn !== 1'b0) line_ok = 1'b0;
            step();
        end
        checks++;
        if (!ready_ok || !pulse_ok || !line_ok) begin
            errors++;
            $display("FAIL timeout window: ready_ok=%b pulse_ok=%b line_ok=%b, want 1 1 1",
                     ready_ok, pulse_ok, line_ok);
        end
        checks++;
        if (Busy !== 1'b0 || RespReady !== 1'b0 || RespTimeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout return: Busy=%b RespReady=%b RespTimeout=%b, want 0 0 0",
                     Busy, RespReady, RespTimeout);
        end
    endtask

    task automatic test_nocrc();
        send_frame(make_cmd(6'd41, 32'h0), "r3_cmd");
        respond(6'h3F, 32'h00FF8000, 1'b1, "r3_resp");
    endtask

    // Back-to-back random traffic; each frame starts in the first IDLE cycle available.
    task automatic test_back_to_back();
        logic [47:0] f;
        for (int n = 0; n < 14; n++) begin
            f = make_cmd(6'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) f = f ^ (48'h1 << $urandom_range(0, 46));
            send_frame(f, "random_cmd");
            if (frame_good(f)) begin
                if ($urandom_range(0, 2) == 0) skip(1'($urandom), "random_skip");
                else respond(6'($urandom), $urandom, 1'($urandom), "random_resp");
            end
        end
    endtask

    task automatic test_reset_mid_send();
        send_frame(48'h400000000095, "pre_reset_cmd0");
        RespValid = 1'b1;
        RespIndex = 6'h2A;
        RespArg   = $urandom;
        RespNoCrc = 1'b0;
        step();
        RespValid = 1'b0;
        for (int i = 1; i < int'(NCR_T); i++) step();
        checks++;
        if (CmdEn !== 1'b1) begin
            errors++;
            $display("FAIL reset_send start: CmdEn=%b, want 1", CmdEn);
        end
        for (int i = 0; i < 20; i++) step();
        #1 nResetAsync = 1'b0;
        #1;
        checks++;
        if (CmdEn !== 1'b0 || CmdOut !== 1'b1 || Busy !== 1'b0 || RespReady !== 1'b0 ||
            CmdIndex !== 6'd0 || CmdArg !== 32'd0) begin
            errors++;
            $display("FAIL reset_send: En=%b Out=%b Busy=%b Rdy=%b idx=%h arg=%h, want 0 1 0 0 0 0",
                     CmdEn, CmdOut, Busy, RespReady, CmdIndex, CmdArg);
        end
        exp_index = '0;
        exp_arg   = '0;
        #2 nResetAsync = 1'b1;
        step();
        send_frame(48'h400000000095, "post_reset_cmd0");
        skip(1'b0, "post_reset_cmd0");
    endtask

    initial begin
        test_reset();
        test_cmd0_skip();
        test_cmd8_response();
        test_crc_error();
        test_timeout();
        test_nocrc();
        test_back_to_back();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_cmd_responder.md
SD_CMD_RESPONDER -- requirements
Module: sd_cmd_responder

Interface
REQ-001 Parameter NCR, default 2, range 2..64: cycles from response handshake to first driven response bit.
REQ-002 Parameter RESP_TIMEOUT, default 64: cycles allowed in WAIT_RESP before the command is abandoned.
REQ-003 Clk  in  1  card-side SD clock; all logic on its rising edge.
REQ-004 nResetAsync  in  1  asynchronous, active-low reset.
REQ-005 CmdIn  in  1  sampled CMD line.
REQ-006 CmdOut  out  1  value driven onto CMD.
REQ-007 CmdEn  out  1  CMD output enable; the line is released when low.
REQ-008 CmdValid  out  1  one-cycle pulse: good command decoded.
REQ-009 CmdIndex  out  6  decoded command index; held until the next CmdValid.
REQ-010 CmdArg  out  32  decoded argument; held until the next CmdValid.
REQ-011 CrcError  out  1  one-cycle pulse: frame rejected.
REQ-012 RespValid  in  1  user offers a response.
REQ-013 RespReady  out  1  responder accepts a response.
REQ-014 RespSkip  in  1  user requests no response (e.g. CMD0).
REQ-015 RespIndex  in  6  response index field.
REQ-016 RespArg  in  32  response payload.
REQ-017 RespNoCrc  in  1  CRC field sent as 7'h7F (R3).
REQ-018 RespTimeout  out  1  one-cycle pulse: WAIT_RESP expired.
REQ-019 Busy  out  1  high in every state except IDLE.

Function
REQ-020 The state machine SHALL have the states IDLE, RECV, CHECK, WAIT_RESP, DELAY and SEND.
REQ-021 In IDLE, CmdIn=0 sampled SHALL be taken as the start bit and the next state SHALL be RECV.
REQ-022 RECV SHALL shift 47 further bits MSB-first, so the frame is 48 bits including the start bit.
REQ-023 The serial CRC7 (x^7+x^3+1, zero seed) SHALL run over frame bits 47..8.
REQ-024 CHECK SHALL occupy the cycle after the end bit is sampled and SHALL accept the frame only if transmission bit = 1, CRC7 = received bits 7..1 and end bit = 1.
REQ-025 An accepted frame SHALL load CmdIndex/CmdArg, pulse CmdValid in the CHECK cycle and go to WAIT_RESP.
REQ-026 A rejected frame SHALL pulse CrcError, leave CmdIndex/CmdArg unchanged and go to IDLE.
REQ-027 RespReady SHALL be high only in WAIT_RESP.
REQ-028 A response handshake occurs when RespValid=1 and RespReady=1; RespIndex, RespArg and RespNoCrc SHALL be latched on that edge and the next state SHALL be DELAY.
REQ-029 RespSkip=1 in WAIT_RESP SHALL return to IDLE with nothing driven; if RespSkip and RespValid are high together, RespSkip SHALL win.
REQ-030 If RESP_TIMEOUT cycles pass in WAIT_RESP with no handshake and no skip, RespTimeout SHALL pulse and the next state SHALL be IDLE.
REQ-031 The first response bit SHALL be driven in the NCR-th cycle after the handshake cycle.
REQ-032 SEND SHALL drive 48 bits MSB-first: 0, 0, RespIndex, RespArg, CRC7 of the first 40 bits or 7'h7F if RespNoCrc, then 1.
REQ-033 CmdEn SHALL be high for exactly the 48 SEND cycles.
REQ-034 Whenever CmdEn=0, CmdOut SHALL be 1.
REQ-035 After the end bit, the next cycle SHALL be IDLE with CmdEn=0.
REQ-036 CmdIn SHALL be ignored in CHECK, WAIT_RESP, DELAY and SEND; no command SHALL be overlapped.
REQ-037 A start bit sampled in the first IDLE cycle after SEND SHALL be accepted.

Reset
REQ-038 Asserting nResetAsync SHALL take effect immediately, including mid-RECV and mid-SEND, and SHALL force: state IDLE, CmdEn 0, CmdOut 1, CmdValid 0, CrcError 0, RespReady 0, RespTimeout 0, Busy 0, CmdIndex 0, CmdArg 0, all counters and the CRC register 0.
REQ-039 Deassertion SHALL be followed by normal operation from IDLE on the next rising edge.

Structure
REQ-040 A shared package SHALL hold the state enum, cCmdFrameLen=48, cCrc7Poly=7'h09 and cNoCrcField=7'h7F.
REQ-041 The sub-module crc7_serial (shift enable, clear, data bit, 7-bit CRC out) SHALL be instantiated once for receive and once for transmit.

Verification
REQ-042 Drive 0x400000000095 (CMD0) -> CmdValid, index 0, arg 0; then RespSkip -> CmdEn never asserts.
REQ-043 Drive 0x48000001AA87 (CMD8); respond index 8, arg 0x000001AA -> start bit exactly NCR cycles after the handshake, 48 bits with CRC7 matching the bench model, end bit 1, then CmdEn low.
REQ-044 Send CMD8 with one argument bit flipped -> CrcError pulse, CmdValid stays 0, registers unchanged; the next valid frame is accepted.
REQ-045 Good command with no response input for 64 cycles -> RespTimeout pulse, return to IDLE, CmdEn never high.
REQ-046 Respond with RespNoCrc=1, index 0x3F, arg 0x00FF8000 -> CRC field 1111111.
REQ-047 Assert reset at bit 20 of SEND -> CmdEn low and CmdOut 1 immediately; a fresh CMD0 after release is decoded.
